// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Definitions shared by the pong game blocks: the paddle controller and the
//   ball mover.
//
//   state_t      : match sequencing state (SERVE / PLAY / OVER).
//   X_MAX, Y_MAX : largest ball coordinate on each axis. The ball wraps past
//                  these, and the paddle controller reads a wrap as a miss.
//   BALL_X_RESET,
//   BALL_Y_RESET : position the ball mover loads while ballResetN is low.
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam int X_MAX        = 63;
    localparam int Y_MAX        = 31;
    localparam int BALL_X_RESET = 8;
    localparam int BALL_Y_RESET = 4;

endpackage

// File: rtl/paddle_controller_if.sv
// -----------------------------------------------------------------------------
// paddle_controller_if
//   Link between the ball mover and the paddle controller.
//
//   xPosition      : ball column, 0..63       (ball mover -> controller)
//   yPosition      : ball row, 0..31          (ball mover -> controller)
//   isHittingLeft  : ball row lies within the left paddle span
//                                             (controller -> ball mover)
//   isHittingRight : ball row lies within the right paddle span
//                                             (controller -> ball mover)
//   ballResetN     : active-low load that holds the ball at its serve position
//                                             (controller -> ball mover)
//
//   modport master : the ball mover side.
//   modport slave  : the paddle controller side.
// -----------------------------------------------------------------------------
interface paddle_controller_if;

    logic [5:0] xPosition;
    logic [4:0] yPosition;
    logic       isHittingLeft;
    logic       isHittingRight;
    logic       ballResetN;

    modport master (
        output xPosition,
        output yPosition,
        input  isHittingLeft,
        input  isHittingRight,
        input  ballResetN
    );

    modport slave (
        input  xPosition,
        input  yPosition,
        output isHittingLeft,
        output isHittingRight,
        output ballResetN
    );

endinterface

// File: rtl/paddle_mover.sv
// -----------------------------------------------------------------------------
// paddle_mover
//   Holds one paddle's vertical position, moves it in response to the player's
//   buttons, and reports whether the ball row lies within the paddle.
//
//   Parameters
//     PADDLE_LEN : paddle height in rows (1..31).
//
//   Ports
//     clk        in   1 : clock.
//     reset      in   1 : synchronous, active-high reset. The paddle returns
//                         to the centre of the field.
//     tick       in   1 : movement strobe from the shared move divider.
//     enable     in   1 : movement allowed. Low freezes the paddle.
//     hitEnable  in   1 : hit reporting allowed. Low forces isHitting to 0.
//     up         in   1 : player up button, as a level.
//     down       in   1 : player down button, as a level.
//     yPosition  in   5 : ball row.
//     paddleY    out  5 : top row of the paddle.
//     isHitting  out  1 : registered result of the paddle span test.
// -----------------------------------------------------------------------------
module paddle_mover
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       hitEnable,
    input  logic       up,
    input  logic       down,
    input  logic [4:0] yPosition,
    output logic [4:0] paddleY,
    output logic       isHitting
);

    // Lowest top row that still keeps the whole paddle on the field.
    localparam logic [4:0] Y_LIMIT = 5'(Y_MAX + 1 - PADDLE_LEN);
    localparam logic [4:0] Y_HOME  = 5'((Y_MAX + 1 - PADDLE_LEN) / 2);

    logic [4:0] r_paddleY;
    logic       r_isHitting;

    logic [5:0] w_top;
    logic [5:0] w_bottom;
    logic [5:0] w_ballRow;
    logic       w_hit;

    // The span test runs in 6 bits. In 5 bits, paddleY + PADDLE_LEN - 1 could
    // wrap past row 31.
    assign w_top     = {1'b0, r_paddleY};
    assign w_bottom  = w_top + 6'(PADDLE_LEN - 1);
    assign w_ballRow = {1'b0, yPosition};
    assign w_hit     = hitEnable && (w_ballRow >= w_top) && (w_ballRow <= w_bottom);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_paddleY   <= Y_HOME;
            r_isHitting <= 1'b0;
        end else begin
            r_isHitting <= w_hit;
            // Pressing both buttons, or neither, holds the paddle still.
            if (enable && tick && (up ^ down)) begin
                if (up) begin
                    if (r_paddleY != 5'd0) begin
                        r_paddleY <= r_paddleY - 5'd1;
                    end
                end else begin
                    if (r_paddleY < Y_LIMIT) begin
                        r_paddleY <= r_paddleY + 5'd1;
                    end
                end
            end
        end
    end

    assign paddleY   = r_paddleY;
    assign isHitting = r_isHitting;

endmodule

// File: rtl/paddle_controller.sv
// -----------------------------------------------------------------------------
// paddle_controller
//   The game-side counterpart to the ball mover. It owns both paddles, detects
//   a miss when the ball coordinate wraps, keeps both scores, and steps the
//   match through serve, play and game over. Between points it holds the ball
//   in its load state.
//
//   Parameters
//     PADDLE_LEN   : paddle height in rows (1..31).
//     MOVE_DIV     : clock cycles per paddle step (>=1).
//     SERVE_CYCLES : cycles that ballResetN stays low before each serve (>=1).
//     WIN_SCORE    : score that ends the game (1..15).
//
//   Ports
//     clk              in   1 : clock.
//     reset            in   1 : synchronous, active-high reset.
//     btnLeftUp/Down   in   1 : left player buttons, already synchronised.
//     btnRightUp/Down  in   1 : right player buttons, already synchronised.
//     ball             slave  : xPosition/yPosition in; isHittingLeft,
//                               isHittingRight and ballResetN out.
//     leftPaddleY      out  5 : top row of the left paddle.
//     rightPaddleY     out  5 : top row of the right paddle.
//     scoreLeft        out  4 : points won by the left player.
//     scoreRight       out  4 : points won by the right player.
//     pointScored      out  1 : one-cycle pulse for each point.
//     gameOver         out  1 : high once a player reaches WIN_SCORE.
// -----------------------------------------------------------------------------
module paddle_controller
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN   = 6,
    parameter int MOVE_DIV     = 4,
    parameter int SERVE_CYCLES = 16,
    parameter int WIN_SCORE    = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btnLeftUp,
    input  logic                btnLeftDown,
    input  logic                btnRightUp,
    input  logic                btnRightDown,
    paddle_controller_if.slave  ball,
    output logic [4:0]          leftPaddleY,
    output logic [4:0]          rightPaddleY,
    output logic [3:0]          scoreLeft,
    output logic [3:0]          scoreRight,
    output logic                pointScored,
    output logic                gameOver
);

    localparam int MOVE_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int SERVE_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;

    localparam logic [MOVE_W-1:0]  MOVE_LAST  = MOVE_W'(MOVE_DIV - 1);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_CYCLES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic [5:0]         X_EDGE     = 6'(X_MAX);

    state_t              r_state;
    state_t              w_next_state;
    logic [SERVE_W-1:0]  r_serve_cnt;
    logic [MOVE_W-1:0]   r_move_cnt;
    logic [5:0]          r_prevX;
    logic                r_missLeft;
    logic                r_missRight;
    logic [3:0]          r_scoreLeft;
    logic [3:0]          r_scoreRight;
    logic                r_pointScored;

    logic                w_tick;
    logic                w_serve_done;
    logic                w_missLeft;
    logic                w_missRight;
    logic                w_pending;
    logic                w_win;
    logic                w_ballResetN;
    logic                w_gameOver;
    logic                w_moveEn;
    logic                w_hitEn;

    assign w_tick       = (r_move_cnt == MOVE_LAST);
    assign w_serve_done = (r_serve_cnt == SERVE_LAST);
    assign w_pending    = r_missLeft || r_missRight;

    // A miss is the ball wrapping from one edge straight to the other. The
    // search is paused while a detected miss waits to be applied, so one wrap
    // can never score twice.
    assign w_missLeft  = (r_state == PLAY) && !w_pending &&
                         (r_prevX == 6'd0) && (ball.xPosition == X_EDGE);
    assign w_missRight = (r_state == PLAY) && !w_pending &&
                         (r_prevX == X_EDGE) && (ball.xPosition == 6'd0);

    // A left miss is a point for the right player, and a right miss is a point
    // for the left player.
    assign w_win = (r_missLeft  && ((r_scoreRight + 4'd1) == WIN)) ||
                   (r_missRight && ((r_scoreLeft  + 4'd1) == WIN));

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SERVE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SERVE: begin
                if (w_serve_done) begin
                    w_next_state = PLAY;
                end
            end
            PLAY: begin
                if (w_pending) begin
                    w_next_state = w_win ? OVER : SERVE;
                end
            end
            OVER: begin
                w_next_state = OVER;
            end
            default: begin
                w_next_state = SERVE;
            end
        endcase
    end

    // ---- FSM: outputs decoded from state ----
    always_comb begin
        w_ballResetN = 1'b0;
        w_gameOver   = 1'b0;
        w_moveEn     = 1'b0;
        w_hitEn      = 1'b0;
        case (r_state)
            SERVE: begin
                w_moveEn = 1'b1;
            end
            PLAY: begin
                w_ballResetN = 1'b1;
                w_moveEn     = 1'b1;
                w_hitEn      = 1'b1;
            end
            OVER: begin
                w_gameOver = 1'b1;
            end
            default: begin
                w_ballResetN = 1'b0;
            end
        endcase
    end

    // Serve timer, move divider, previous x, miss flags and scores.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_serve_cnt   <= '0;
            r_move_cnt    <= '0;
            r_prevX       <= 6'(BALL_X_RESET);
            r_missLeft    <= 1'b0;
            r_missRight   <= 1'b0;
            r_scoreLeft   <= 4'd0;
            r_scoreRight  <= 4'd0;
            r_pointScored <= 1'b0;
        end else begin
            if (r_state == SERVE && !w_serve_done) begin
                r_serve_cnt <= r_serve_cnt + SERVE_W'(1);
            end else begin
                r_serve_cnt <= '0;
            end

            r_move_cnt <= w_tick ? '0 : r_move_cnt + MOVE_W'(1);

            r_prevX       <= ball.xPosition;
            r_missLeft    <= w_missLeft;
            r_missRight   <= w_missRight;
            r_pointScored <= w_pending;

            // Both scores saturate at WIN_SCORE.
            if (r_missLeft && (r_scoreRight < WIN)) begin
                r_scoreRight <= r_scoreRight + 4'd1;
            end
            if (r_missRight && (r_scoreLeft < WIN)) begin
                r_scoreLeft <= r_scoreLeft + 4'd1;
            end
        end
    end

    paddle_mover #(
        .PADDLE_LEN (PADDLE_LEN)
    ) u_left (
        .clk       (clk),
        .reset     (reset),
        .tick      (w_tick),
        .enable    (w_moveEn),
        .hitEnable (w_hitEn),
        .up        (btnLeftUp),
        .down      (btnLeftDown),
        .yPosition (ball.yPosition),
        .paddleY   (leftPaddleY),
        .isHitting (ball.isHittingLeft)
    );

    paddle_mover #(
        .PADDLE_LEN (PADDLE_LEN)
    ) u_right (
        .clk       (clk),
        .reset     (reset),
        .tick      (w_tick),
        .enable    (w_moveEn),
        .hitEnable (w_hitEn),
        .up        (btnRightUp),
        .down      (btnRightDown),
        .yPosition (ball.yPosition),
        .paddleY   (rightPaddleY),
        .isHitting (ball.isHittingRight)
    );

    assign ball.ballResetN = w_ballResetN;
    assign gameOver        = w_gameOver;
    assign scoreLeft       = r_scoreLeft;
    assign scoreRight      = r_scoreRight;
    assign pointScored     = r_pointScored;

endmodule

// File: tb/tb_paddle_controller.sv
// -----------------------------------------------------------------------------
// tb_paddle_controller
//   Directed bench for paddle_controller at its default parameters
//   (PADDLE_LEN=6, MOVE_DIV=4, SERVE_CYCLES=16, WIN_SCORE=9).
// -----------------------------------------------------------------------------
module tb_paddle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnLeftUp, btnLeftDown, btnRightUp, btnRightDown;
    logic [4:0] leftPaddleY, rightPaddleY;
    logic [3:0] scoreLeft, scoreRight;
    logic       pointScored, gameOver;

    int n_cmp  = 0;
    int n_fail = 0;

    paddle_controller_if bus ();

    paddle_controller #(
        .PADDLE_LEN   (6),
        .MOVE_DIV     (4),
        .SERVE_CYCLES (16),
        .WIN_SCORE    (9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btnLeftUp    (btnLeftUp),
        .btnLeftDown  (btnLeftDown),
        .btnRightUp   (btnRightUp),
        .btnRightDown (btnRightDown),
        .ball         (bus),
        .leftPaddleY  (leftPaddleY),
        .rightPaddleY (rightPaddleY),
        .scoreLeft    (scoreLeft),
        .scoreRight   (scoreRight),
        .pointScored  (pointScored),
        .gameOver     (gameOver)
    );

    always #5 clk = ~clk;

    // Advance n rising edges. Outputs are sampled and inputs are driven 1 ns
    // after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        btnLeftUp = 0; btnLeftDown = 0; btnRightUp = 0; btnRightDown = 0;
        bus.xPosition = 6'd8;
        bus.yPosition = 5'd4;
        cyc(3);
        n_cmp++; if (bus.ballResetN !== 1'b0) begin n_fail++; $display("FAIL reset_ballResetN got %0d want 0", bus.ballResetN); end
        n_cmp++; if (leftPaddleY !== 5'd13) begin n_fail++; $display("FAIL reset_leftY got %0d want 13", leftPaddleY); end
        n_cmp++; if (rightPaddleY !== 5'd13) begin n_fail++; $display("FAIL reset_rightY got %0d want 13", rightPaddleY); end
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'd0) begin n_fail++; $display("FAIL reset_scores got %0d/%0d want 0/0", scoreLeft, scoreRight); end
        n_cmp++; if ({gameOver, pointScored} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got go=%0d ps=%0d want 0/0", gameOver, pointScored); end
        n_cmp++; if ({bus.isHittingLeft, bus.isHittingRight} !== 2'b00) begin n_fail++; $display("FAIL reset_hit got %0d%0d want 00", bus.isHittingLeft, bus.isHittingRight); end
        reset = 1'b0;
    endtask

    // Wait through a full serve, which starts on the edge where reset is
    // released or SERVE is entered. Call immediately after that edge
    // (already_done edges into it).
    task automatic test_serve(input string tag, input int already_done);
        cyc(15 - already_done);
        n_cmp++; if (bus.ballResetN !== 1'b0) begin n_fail++; $display("FAIL %s_serve_low got %0d want 0", tag, bus.ballResetN); end
        cyc(1);
        n_cmp++; if (bus.ballResetN !== 1'b1) begin n_fail++; $display("FAIL %s_serve_high got %0d want 1", tag, bus.ballResetN); end
        n_cmp++; if (gameOver !== 1'b0) begin n_fail++; $display("FAIL %s_serve_gameOver got %0d want 0", tag, gameOver); end
    endtask

    task automatic test_hit;
        // Both paddles at 13 span rows 13..18. The ball row is still 4.
        n_cmp++; if (bus.isHittingRight !== 1'b0) begin n_fail++; $display("FAIL hit_y4 got %0d want 0", bus.isHittingRight); end
        bus.yPosition = 5'd13;
        #1;
        n_cmp++; if (bus.isHittingRight !== 1'b0) begin n_fail++; $display("FAIL hit_y13_latency got %0d want 0", bus.isHittingRight); end
        cyc(1);
        n_cmp++; if (bus.isHittingRight !== 1'b1) begin n_fail++; $display("FAIL hit_y13 got %0d want 1", bus.isHittingRight); end
        n_cmp++; if (bus.isHittingLeft !== 1'b1) begin n_fail++; $display("FAIL hitL_y13 got %0d want 1", bus.isHittingLeft); end
        bus.yPosition = 5'd18;
        cyc(1);
        n_cmp++; if (bus.isHittingRight !== 1'b1) begin n_fail++; $display("FAIL hit_y18 got %0d want 1", bus.isHittingRight); end
        bus.yPosition = 5'd19;
        #1;
        n_cmp++; if (bus.isHittingRight !== 1'b1) begin n_fail++; $display("FAIL hit_y19_latency got %0d want 1", bus.isHittingRight); end
        cyc(1);
        n_cmp++; if (bus.isHittingRight !== 1'b0) begin n_fail++; $display("FAIL hit_y19 got %0d want 0", bus.isHittingRight); end
    endtask

    task automatic test_buttons;
        logic [4:0] prev;
        int steps, gap, bad;
        btnLeftUp = 1'b1;
        prev = leftPaddleY; steps = 0; gap = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            gap++;
            if (leftPaddleY != prev) begin
                // Each step is one row up, exactly MOVE_DIV cycles after the
                // last. The first step must come within MOVE_DIV cycles.
                if (leftPaddleY != prev - 5'd1) bad++;
                if (steps == 0 ? (gap > 4) : (gap != 4)) bad++;
                steps++; gap = 0; prev = leftPaddleY;
            end
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL btn_step_shape got %0d bad steps want 0", bad); end
        n_cmp++; if (steps !== 13) begin n_fail++; $display("FAIL btn_step_count got %0d want 13", steps); end
        n_cmp++; if (leftPaddleY !== 5'd0) begin n_fail++; $display("FAIL btn_up_sat got %0d want 0", leftPaddleY); end
        n_cmp++; if (rightPaddleY !== 5'd13) begin n_fail++; $display("FAIL btn_right_idle got %0d want 13", rightPaddleY); end
        btnLeftDown = 1'b1;
        cyc(20);
        n_cmp++; if (leftPaddleY !== 5'd0) begin n_fail++; $display("FAIL btn_both_hold got %0d want 0", leftPaddleY); end
        btnLeftUp = 1'b0; btnLeftDown = 1'b0;
        btnRightDown = 1'b1;
        cyc(100);
        n_cmp++; if (rightPaddleY !== 5'd26) begin n_fail++; $display("FAIL btn_down_sat got %0d want 26", rightPaddleY); end
        btnRightDown = 1'b0;
    endtask

    task automatic test_left_miss;
        bus.xPosition = 6'd1; cyc(1);
        bus.xPosition = 6'd0; cyc(1);
        bus.xPosition = 6'd63; cyc(1);
        // The miss is now registered but not yet applied.
        n_cmp++; if (scoreRight !== 4'd0) begin n_fail++; $display("FAIL miss_early_score got %0d want 0", scoreRight); end
        n_cmp++; if (pointScored !== 1'b0) begin n_fail++; $display("FAIL miss_early_pulse got %0d want 0", pointScored); end
        cyc(1);
        n_cmp++; if (scoreRight !== 4'd1) begin n_fail++; $display("FAIL miss_scoreRight got %0d want 1", scoreRight); end
        n_cmp++; if (scoreLeft !== 4'd0) begin n_fail++; $display("FAIL miss_scoreLeft got %0d want 0", scoreLeft); end
        n_cmp++; if (pointScored !== 1'b1) begin n_fail++; $display("FAIL miss_pulse got %0d want 1", pointScored); end
        n_cmp++; if (bus.ballResetN !== 1'b0) begin n_fail++; $display("FAIL miss_ballResetN got %0d want 0", bus.ballResetN); end
        bus.xPosition = 6'd8;
        cyc(1);
        n_cmp++; if (pointScored !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_end got %0d want 0", pointScored); end
        n_cmp++; if (scoreRight !== 4'd1) begin n_fail++; $display("FAIL miss_score_hold got %0d want 1", scoreRight); end
        test_serve("miss", 1);
    endtask

    task automatic test_reset_mid;
        bus.xPosition = 6'd63; cyc(1);
        bus.xPosition = 6'd0; cyc(1);
        reset = 1'b1;
        cyc(1);
        n_cmp++; if (pointScored !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse got %0d want 0", pointScored); end
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'd0) begin n_fail++; $display("FAIL rstmid_scores got %0d/%0d want 0/0", scoreLeft, scoreRight); end
        n_cmp++; if (bus.ballResetN !== 1'b0) begin n_fail++; $display("FAIL rstmid_ballResetN got %0d want 0", bus.ballResetN); end
        n_cmp++; if ({leftPaddleY, rightPaddleY} !== {5'd13, 5'd13}) begin n_fail++; $display("FAIL rstmid_paddles got %0d/%0d want 13/13", leftPaddleY, rightPaddleY); end
        reset = 1'b0;
        bus.xPosition = 6'd8;
        cyc(1);
        n_cmp++; if (pointScored !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse_late got %0d want 0", pointScored); end
        test_serve("rstmid", 1);
    endtask

    task automatic test_game_over;
        for (int i = 1; i <= 9; i++) begin
            bus.xPosition = 6'd63; cyc(1);
            bus.xPosition = 6'd0;  cyc(1);
            cyc(1);
            bus.xPosition = 6'd8;
            n_cmp++; if (scoreLeft !== 4'(i)) begin n_fail++; $display("FAIL go_scoreLeft_%0d got %0d want %0d", i, scoreLeft, i); end
            n_cmp++; if (pointScored !== 1'b1) begin n_fail++; $display("FAIL go_pulse_%0d got %0d want 1", i, pointScored); end
            n_cmp++; if (gameOver !== (i == 9)) begin n_fail++; $display("FAIL go_flag_%0d got %0d want %0d", i, gameOver, (i == 9)); end
            n_cmp++; if (bus.ballResetN !== 1'b0) begin n_fail++; $display("FAIL go_ballResetN_%0d got %0d want 0", i, bus.ballResetN); end
            if (i < 9) begin
                cyc(16);
                n_cmp++; if (bus.ballResetN !== 1'b1) begin n_fail++; $display("FAIL go_replay_%0d got %0d want 1", i, bus.ballResetN); end
            end
        end
        cyc(1);
        n_cmp++; if (pointScored !== 1'b0) begin n_fail++; $display("FAIL go_pulse_end got %0d want 0", pointScored); end
        btnLeftUp = 1'b1; btnRightDown = 1'b1;
        bus.yPosition = 5'd14;
        cyc(20);
        n_cmp++; if ({leftPaddleY, rightPaddleY} !== {5'd13, 5'd13}) begin n_fail++; $display("FAIL go_frozen got %0d/%0d want 13/13", leftPaddleY, rightPaddleY); end
        n_cmp++; if ({bus.isHittingLeft, bus.isHittingRight} !== 2'b00) begin n_fail++; $display("FAIL go_hit got %0d%0d want 00", bus.isHittingLeft, bus.isHittingRight); end
        n_cmp++; if (bus.ballResetN !== 1'b0) begin n_fail++; $display("FAIL go_hold_ballResetN got %0d want 0", bus.ballResetN); end
        btnLeftUp = 1'b0; btnRightDown = 1'b0;
        bus.xPosition = 6'd63; cyc(1);
        bus.xPosition = 6'd0;  cyc(3);
        n_cmp++; if ({scoreLeft, scoreRight} !== {4'd9, 4'd0}) begin n_fail++; $display("FAIL go_extra_wrap got %0d/%0d want 9/0", scoreLeft, scoreRight); end
        n_cmp++; if (pointScored !== 1'b0) begin n_fail++; $display("FAIL go_extra_pulse got %0d want 0", pointScored); end
        n_cmp++; if (gameOver !== 1'b1) begin n_fail++; $display("FAIL go_stays got %0d want 1", gameOver); end
    endtask

    initial begin
        test_reset();
        test_serve("init", 0);
        test_hit();
        test_buttons();
        test_left_miss();
        test_reset_mid();
        test_game_over();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
